uart_host_ctrl: RTL and testbench

Host-side controller for the UART chip's parallel bus. It converts two valid/ready byte streams into correctly timed `wrn`/`rdn` strobe sequences on the UART's `din`/`dout`/`tbre`/`data_ready` pins. Small TX and RX FIFOs decouple the user logic from the UART's serial pace. It sits between system logic and the `uart` instance, in the same `clk16x` domain.

---
 rtl/uart_host_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_uart_host_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_ctrl.sv
// Host-side controller for the UART parallel bus: TX/RX byte FIFOs plus wrn/rdn strobe FSMs.
// Optional feature macro UART_HOST_ERRDROP_EN: drop error-flagged RX bytes and count them on err_cnt.

module uart_host_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  // When full, a same-cycle pop frees the head slot the push then reuses.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end
endmodule

module uart_host_ctrl #(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned WR_PULSE = 2,
  parameter int unsigned RD_PULSE = 2,
  parameter int unsigned ACK_TMO  = 16
) (
  input  logic       clk16x,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_fe,
  output logic       rx_pe,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       idle,
  output logic       tmo_err,
  output logic [7:0] din,
  output logic       wrn,
  output logic       rdn,
  input  logic [7:0] dout,
  input  logic       tbre,
  input  logic       tsre,
  input  logic       data_ready,
  input  logic       framing_error,
  input  logic       parity_error
`ifdef UART_HOST_ERRDROP_EN
  ,
  output logic [7:0] err_cnt
`endif
);
  localparam int unsigned CNT_MAX = (ACK_TMO > 16) ? ACK_TMO : 16;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
`ifdef UART_HOST_ERRDROP_EN
  localparam int unsigned RXW = 8;
`else
  localparam int unsigned RXW = 10;
`endif

  typedef enum logic [2:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD, W_ACK} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_STROBE, R_CLR} rstate_t;

  wstate_t       r_wstate, w_wstate_nxt;
  rstate_t       r_rstate, w_rstate_nxt;
  logic [CW-1:0] r_wcnt, r_rcnt;
  logic          r_wrn, r_rdn, r_tmo;
  logic [7:0]    r_din;

  logic           w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0]     w_tx_head;
  logic           w_rx_push, w_rx_full, w_rx_empty;
  logic [RXW-1:0] w_rx_in, w_rx_head;
  logic           w_rd_last, w_wtmo, w_rtmo;

  assign tx_ready = ~w_tx_full;
  assign rx_valid = ~w_rx_empty;
  assign idle     = w_tx_empty & (r_wstate == W_IDLE) & tsre;
  assign din      = r_din;
  assign wrn      = r_wrn;
  assign rdn      = r_rdn;
  assign tmo_err  = r_tmo;

  uart_host_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .i_clk   (clk16x),
    .i_rst_n (rst),
    .i_push  (tx_valid & tx_ready),
    .i_data  (tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  uart_host_fifo #(.DEPTH(RX_DEPTH), .W(RXW)) u_rx_fifo (
    .i_clk   (clk16x),
    .i_rst_n (rst),
    .i_push  (w_rx_push),
    .i_data  (w_rx_in),
    .i_pop   (rx_ready),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

`ifdef UART_HOST_ERRDROP_EN
  logic [7:0] r_err_cnt;
  logic       w_rx_err;

  assign w_rx_err  = framing_error | parity_error;
  assign w_rx_push = w_rd_last & ~w_rx_err;
  assign w_rx_in   = dout;
  assign rx_data   = w_rx_head;
  assign rx_fe     = 1'b0;
  assign rx_pe     = 1'b0;
  assign err_cnt   = r_err_cnt;

  always_ff @(posedge clk16x or negedge rst) begin
    if (!rst)                                       r_err_cnt <= '0;
    else if (w_rd_last && w_rx_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
  end
`else
  assign w_rx_push = w_rd_last;
  assign w_rx_in   = {parity_error, framing_error, dout};
  assign rx_data   = w_rx_head[7:0];
  assign rx_fe     = w_rx_head[8];
  assign rx_pe     = w_rx_head[9];
`endif

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_tx_pop     = 1'b0;
    w_wtmo       = 1'b0;
    unique case (r_wstate)
      W_IDLE:   if (!w_tx_empty && tbre) begin
                  w_wstate_nxt = W_SETUP;
                  w_tx_pop     = 1'b1;
                end
      W_SETUP:  w_wstate_nxt = W_STROBE;
      W_STROBE: if (r_wcnt == CW'(WR_PULSE - 1)) w_wstate_nxt = W_HOLD;
      W_HOLD:   w_wstate_nxt = W_ACK;
      W_ACK:    if (!tbre) w_wstate_nxt = W_IDLE;
                else if (r_wcnt == CW'(ACK_TMO - 1)) begin
                  w_wstate_nxt = W_IDLE;
                  w_wtmo       = 1'b1;
                end
      default:  w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rd_last    = 1'b0;
    w_rtmo       = 1'b0;
    unique case (r_rstate)
      R_IDLE:   if (data_ready && !w_rx_full) w_rstate_nxt = R_STROBE;
      R_STROBE: if (r_rcnt == CW'(RD_PULSE - 1)) begin
                  w_rstate_nxt = R_CLR;
                  w_rd_last    = 1'b1;
                end
      R_CLR:    if (!data_ready) w_rstate_nxt = R_IDLE;
                else if (r_rcnt == CW'(ACK_TMO - 1)) begin
                  w_rstate_nxt = R_IDLE;
                  w_rtmo       = 1'b1;
                end
      default:  w_rstate_nxt = R_IDLE;
    endcase
  end

  // Per-state counters restart on every state change; they time strobes and handshake waits.
  always_ff @(posedge clk16x or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
      r_wcnt   <= '0;
      r_rcnt   <= '0;
      r_wrn    <= 1'b1;
      r_rdn    <= 1'b1;
      r_din    <= '0;
      r_tmo    <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_rstate <= w_rstate_nxt;
      r_wcnt   <= (w_wstate_nxt != r_wstate) ? '0 : r_wcnt + 1'b1;
      r_rcnt   <= (w_rstate_nxt != r_rstate) ? '0 : r_rcnt + 1'b1;
      r_wrn    <= (w_wstate_nxt != W_STROBE);
      r_rdn    <= (w_rstate_nxt != R_STROBE);
      if (w_tx_pop) r_din <= w_tx_head;
      r_tmo    <= r_tmo | w_wtmo | w_rtmo;
    end
  end
endmodule

// File: tb/tb_uart_host_ctrl.sv
// Scoreboard bench for uart_host_ctrl: stimulus queues expected writes/reads, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_uart_host_ctrl;
  localparam int WRP = 2;
  localparam int RDP = 2;

  logic       clk16x, rst;
  logic [7:0] tx_data, rx_data, din, dout;
  logic       tx_valid, tx_ready, rx_fe, rx_pe, rx_valid, rx_ready;
  logic       idle, tmo_err, wrn, rdn, tbre, tsre, data_ready, framing_error, parity_error;
`ifdef UART_HOST_ERRDROP_EN
  logic [7:0] err_cnt;
`endif

  uart_host_ctrl #(.TX_DEPTH(4), .RX_DEPTH(4), .WR_PULSE(2), .RD_PULSE(2), .ACK_TMO(16)) dut (
    .clk16x(clk16x), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_fe(rx_fe), .rx_pe(rx_pe), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .idle(idle), .tmo_err(tmo_err), .din(din), .wrn(wrn), .rdn(rdn), .dout(dout),
    .tbre(tbre), .tsre(tsre), .data_ready(data_ready), .framing_error(framing_error),
    .parity_error(parity_error)
`ifdef UART_HOST_ERRDROP_EN
    , .err_cnt(err_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int n_wr = 0;
  int n_rd = 0;
  logic [7:0] wq[$];
  logic [9:0] rq[$];

  // UART model state, owned by the stimulus process
  logic auto_tbre, wrn_m, rdn_m;
  int   tphase, tcnt, rlen, n0, errs;
  logic exp_push;
  logic [9:0] v;
  logic [9:0] rd_vec [3] = '{10'h23C, 10'h1C3, 10'h05A};  // {pe, fe, data}

  initial begin
    clk16x = 1'b0;
    forever #5 clk16x = ~clk16x;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout required DUT event", name);
  endtask

  task automatic model_step();
    if (auto_tbre) begin
      if (wrn && !wrn_m) tphase = 1;
      else if (tphase == 1) begin tbre = 1'b0; tphase = 2; tcnt = 3; end
      else if (tphase == 2) begin
        tcnt--;
        if (tcnt == 0) begin tbre = 1'b1; tphase = 0; end
      end
    end
    if (!rdn) begin
      if (rdn_m) begin n_rd++; rlen = 0; end
      rlen++;
    end else if (!rdn_m) begin
      chk("rdn_len", rlen, RDP);
      data_ready = 1'b0;
    end
    wrn_m = wrn;
    rdn_m = rdn;
  endtask

  task automatic tick();
    @(posedge clk16x);
    #1;
    if (rst) model_step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin tick(); n++; end
    if (!tx_ready) bound_fail("push_wait");
    else begin
      wq.push_back(b);
      tick();
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 200) begin tick(); n++; end
    chk("idle", idle, 1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    int n = 0;
    dout = b;
    framing_error = 1'b0;
    parity_error = 1'b0;
    rq.push_back({2'b00, b});
    data_ready = 1'b1;
    while (data_ready && n < 50) begin tick(); n++; end
    if (data_ready) bound_fail("rx_handshake");
    tick();
  endtask

  // Monitor: checks every completed wrn pulse and every RX pop against the queues
  initial begin
    logic wrn_q;
    int wlen;
    logic [7:0] wdin, din_q;
    wrn_q = 1'b1; wlen = 0; wdin = '0; din_q = '0;
    forever begin
      @(negedge clk16x);
      if (!rst) begin
        wrn_q = 1'b1;
        wlen = 0;
      end else begin
        if (!wrn) begin
          if (wrn_q) begin
            chk("din_setup", din, din_q);
            wdin = din;
            wlen = 0;
            n_wr++;
          end else chk("din_stable", din, wdin);
          wlen++;
        end else if (!wrn_q) begin
          chk("wrn_len", wlen, WRP);
          chk("din_hold", din, wdin);
          if (wq.size() == 0) begin
            checks++; failures++;
            $display("FAIL write_data: got 0x%0h required no write", wdin);
          end else chk("write_data", wdin, wq.pop_front());
        end
        if (rx_valid && rx_ready) begin
          if (rq.size() == 0) begin
            checks++; failures++;
            $display("FAIL rx_word: got 0x%0h required no data", {rx_pe, rx_fe, rx_data});
          end else chk("rx_word", {rx_pe, rx_fe, rx_data}, rq.pop_front());
        end
        wrn_q = wrn;
        din_q = din;
      end
    end
  end

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0; dout = '0;
    tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0; framing_error = 1'b0; parity_error = 1'b0;
    auto_tbre = 1'b0; wrn_m = 1'b1; rdn_m = 1'b1; tphase = 0; tcnt = 0; rlen = 0; errs = 0;
    #2 rst = 1'b0;
    #10;
    chk("rst_wrn", wrn, 1);
    chk("rst_rdn", rdn, 1);
    chk("rst_din", din, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_word", {rx_pe, rx_fe, rx_data}, 0);
    chk("rst_tmo", tmo_err, 0);
    chk("rst_idle_tsre1", idle, 1);
    tsre = 1'b0;
    #1 chk("rst_idle_tsre0", idle, 0);
    tsre = 1'b1;
    @(negedge clk16x) rst = 1'b1;
    tick();

    // Single write with exact strobe timing
    auto_tbre = 1'b1;
    push_byte(8'hA5);
    chk("lat_c0_wrn", wrn, 1);
    tick(); chk("lat_c1_din", din, 8'hA5); chk("lat_c1_wrn", wrn, 1);
    tick(); chk("lat_c2_wrn", wrn, 0);
    tick(); chk("lat_c3_wrn", wrn, 0);
    tick(); chk("lat_c4_wrn", wrn, 1);
    wait_idle();
    chk("single_wr_count", n_wr, 1);

    // TX backpressure
    auto_tbre = 1'b0; tbre = 1'b0;
    n0 = n_wr;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    chk("tx_full", tx_ready, 0);
    tx_data = 8'h05; tx_valid = 1'b1;
    repeat (10) tick();
    chk("tx_still_full", tx_ready, 0);
    chk("no_wrn_while_busy", n_wr, n0);
    tbre = 1'b1; tphase = 0; auto_tbre = 1'b1;
    push_byte(8'h05);
    wait_idle();
    chk("bp_wr_count", n_wr, n0 + 5);

    // Reads with error flags, checking rx_valid latency
    rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = rd_vec[i];
      dout = v[7:0]; framing_error = v[8]; parity_error = v[9];
`ifdef UART_HOST_ERRDROP_EN
      exp_push = (v[9:8] == 2'b00);
      if (!exp_push) errs++;
`else
      exp_push = 1'b1;
`endif
      if (exp_push) rq.push_back(v);
      n0 = n_rd;
      data_ready = 1'b1;
      tick(); tick();
      chk("rx_lat_early", rx_valid, 0);
      tick();
      chk("rx_lat", rx_valid, exp_push);
      chk("rd_count", n_rd, n0 + 1);
`ifdef UART_HOST_ERRDROP_EN
      chk("err_cnt", err_cnt, errs);
`endif
      framing_error = 1'b0; parity_error = 1'b0;
      tick();
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
      chk("rx_empty_after_pop", rx_valid, 0);
    end

    // RX full: fifth byte must wait for a pop
    n0 = n_rd;
    for (int i = 0; i < 4; i++) send_rx(8'(8'h10 + i));
    chk("rx_stored4", n_rd, n0 + 4);
    dout = 8'h14;
    rq.push_back(10'h014);
    data_ready = 1'b1;
    repeat (10) tick();
    chk("rx_full_no_rdn", n_rd, n0 + 4);
    chk("rx_full_rdn_high", rdn, 1);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    for (int n = 0; n < 50 && data_ready; n++) tick();
    if (data_ready) bound_fail("rx_after_pop");
    chk("rx_fifth_read", n_rd, n0 + 5);
    tick();
    rx_ready = 1'b1;
    repeat (8) tick();
    rx_ready = 1'b0;
    chk("rx_drained", rx_valid, 0);
    chk("rq_empty", rq.size(), 0);

    // Handshake timeout on W_ACK
    auto_tbre = 1'b0; tbre = 1'b1;
    chk("tmo_before", tmo_err, 0);
    n0 = n_wr;
    push_byte(8'h77);
    repeat (20) tick();
    chk("tmo_not_yet", tmo_err, 0);
    tick();
    chk("tmo_set", tmo_err, 1);
    push_byte(8'h88);
    wait_idle();
    chk("tmo_next_written", n_wr, n0 + 2);
    chk("tmo_sticky", tmo_err, 1);

    // Reset while wrn is low, with a byte parked in the RX FIFO
    send_rx(8'h66);
    chk("rx_parked", rx_valid, 1);
    auto_tbre = 1'b1; tphase = 0;
    push_byte(8'h99);
    for (int n = 0; n < 50 && wrn; n++) tick();
    if (wrn) bound_fail("wait_wrn_low");
    #2 rst = 1'b0;
    wq.delete();
    rq.delete();
    #1;
    chk("arst_wrn", wrn, 1);
    chk("arst_rdn", rdn, 1);
    chk("arst_tx_ready", tx_ready, 1);
    chk("arst_rx_valid", rx_valid, 0);
    chk("arst_tmo", tmo_err, 0);
    chk("arst_idle", idle, 1);
    tbre = 1'b1; tphase = 0; wrn_m = 1'b1; rdn_m = 1'b1; data_ready = 1'b0;
    @(negedge clk16x) rst = 1'b1;
    tick();
    n0 = n_wr;
    push_byte(8'h42);
    wait_idle();
    chk("post_rst_write", n_wr, n0 + 1);
    repeat (4) tick();
    chk("wq_empty", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
